// File: rtl/ctu_cluster_rst_seq.sv
// ctu_cluster_rst_seq
// CTU-side sequencer for the cluster-header interface. It staggers the
// per-cluster clock enables on power-on, then releases the global reset and
// finally the global debug init, each after a hold-off long enough for the
// header synchronizers to settle. It also runs warm-reset and standalone
// debug-init sequences on request from RUN, and pulses seq_done whenever the
// sequencer re-enters RUN.
//
// Handshake note: por_req is a level that is sampled on every gclk edge in
// any state. wrm_req and dbg_req are single-cycle pulses. They have no ready
// or acknowledge. A pulse that arrives while the sequencer is busy is
// remembered in a pending flag and is serviced on the first edge spent in
// RUN. Repeated pulses collapse into one. Warm reset always wins over debug
// init, and servicing a warm reset clears both pending flags.

module ctu_cluster_rst_seq #(
  parameter int NUM_CLUSTERS = 4,
  parameter int STAGGER_CYC  = 4,
  parameter int SYNC_CYC     = 8,
  parameter int DBG_CYC      = 16,
  parameter int CNTW         = 8
) (
  input  logic                    gclk,
  input  logic                    arst,
  input  logic [NUM_CLUSTERS-1:0] cken_mask,
  input  logic                    por_req,
  input  logic                    wrm_req,
  input  logic                    dbg_req,
  output logic [NUM_CLUSTERS-1:0] cluster_cken,
  output logic                    grst_l,
  output logic                    gdbginit_l,
  output logic                    seq_busy,
  output logic                    seq_done
);

  // Slot index width. It is kept at least one bit wide so that a
  // single-cluster build still has a legal index register.
  localparam int IDXW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;

  localparam logic [CNTW-1:0] STAGGER_LAST = CNTW'(STAGGER_CYC - 1);
  localparam logic [CNTW-1:0] SYNC_LAST    = CNTW'(SYNC_CYC - 1);
  localparam logic [CNTW-1:0] DBG_LAST     = CNTW'(DBG_CYC - 1);
  localparam logic [IDXW-1:0] IDX_LAST     = IDXW'(NUM_CLUSTERS - 1);

  // The sequencer states. The current state is held in seq_state so that a
  // checker can bind to it directly.
  typedef enum logic [2:0] {
    ST_PWR_CKEN  = 3'd0,  // staggered clock-enable turn-on, one slot per cluster
    ST_RST_HOLD  = 3'd1,  // clocks stable, reset and dbginit held low
    ST_DBG_HOLD  = 3'd2,  // reset released, dbginit still held low
    ST_RUN       = 3'd3,  // normal operation
    ST_DBG_PULSE = 3'd4   // standalone debug-init pulse, reset stays high
  } seq_state_t;

  seq_state_t              seq_state, seq_state_nxt;
  logic [CNTW-1:0]         cnt, cnt_nxt;
  logic [IDXW-1:0]         idx, idx_nxt;
  logic [NUM_CLUSTERS-1:0] cken_q, cken_nxt;
  logic                    grst_q, grst_nxt;
  logic                    gdbg_q, gdbg_nxt;
  logic                    done_q, done_nxt;
  logic                    pend_wrm, pend_wrm_nxt;
  logic                    pend_dbg, pend_dbg_nxt;

  logic                    want_wrm;
  logic                    want_dbg;

  // A request counts in RUN whether it arrives now or was parked earlier.
  assign want_wrm = wrm_req | pend_wrm;
  assign want_dbg = dbg_req | pend_dbg;

  // State and output registers. Every header-facing output comes from a flop.
  always_ff @(posedge gclk or posedge arst) begin
    if (arst) begin
      seq_state <= ST_PWR_CKEN;
      cnt       <= '0;
      idx       <= '0;
      cken_q    <= '0;
      grst_q    <= 1'b0;
      gdbg_q    <= 1'b0;
      done_q    <= 1'b0;
      pend_wrm  <= 1'b0;
      pend_dbg  <= 1'b0;
    end else begin
      seq_state <= seq_state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      cken_q    <= cken_nxt;
      grst_q    <= grst_nxt;
      gdbg_q    <= gdbg_nxt;
      done_q    <= done_nxt;
      pend_wrm  <= pend_wrm_nxt;
      pend_dbg  <= pend_dbg_nxt;
    end
  end

  // Next-state logic: sequence timing, request parking, and the por override.
  always_comb begin
    seq_state_nxt = seq_state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    cken_nxt      = cken_q;
    grst_nxt      = grst_q;
    gdbg_nxt      = gdbg_q;
    done_nxt      = 1'b0;
    pend_wrm_nxt  = pend_wrm;
    pend_dbg_nxt  = pend_dbg;

    // Requests that arrive while busy are parked until the first RUN edge.
    if (seq_state != ST_RUN) begin
      pend_wrm_nxt = pend_wrm | wrm_req;
      pend_dbg_nxt = pend_dbg | dbg_req;
    end

    case (seq_state)
      ST_PWR_CKEN: begin
        if (cnt == STAGGER_LAST) begin
          cnt_nxt       = '0;
          // A masked cluster still uses its slot, so the spacing stays fixed.
          cken_nxt[idx] = cken_mask[idx];
          if (idx == IDX_LAST) begin
            idx_nxt       = '0;
            seq_state_nxt = ST_RST_HOLD;
          end else begin
            idx_nxt = idx + IDXW'(1);
          end
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end

      ST_RST_HOLD: begin
        if (cnt == SYNC_LAST) begin
          cnt_nxt       = '0;
          grst_nxt      = 1'b1;
          seq_state_nxt = ST_DBG_HOLD;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end

      ST_DBG_HOLD: begin
        if (cnt == SYNC_LAST) begin
          cnt_nxt       = '0;
          gdbg_nxt      = 1'b1;
          done_nxt      = 1'b1;
          seq_state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end

      ST_RUN: begin
        if (want_wrm) begin
          // Warm reset keeps the clocks running. A debug init that arrives
          // with it is dropped, because the warm sequence re-inits anyway.
          grst_nxt      = 1'b0;
          gdbg_nxt      = 1'b0;
          cnt_nxt       = '0;
          pend_wrm_nxt  = 1'b0;
          pend_dbg_nxt  = 1'b0;
          seq_state_nxt = ST_RST_HOLD;
        end else if (want_dbg) begin
          gdbg_nxt      = 1'b0;
          cnt_nxt       = '0;
          pend_dbg_nxt  = 1'b0;
          seq_state_nxt = ST_DBG_PULSE;
        end else begin
          // Software clock control is live only while nothing is sequencing.
          cken_nxt = cken_mask;
        end
      end

      ST_DBG_PULSE: begin
        if (cnt == DBG_LAST) begin
          cnt_nxt       = '0;
          gdbg_nxt      = 1'b1;
          done_nxt      = 1'b1;
          seq_state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end

      default: begin
        seq_state_nxt = ST_PWR_CKEN;
        cnt_nxt       = '0;
        idx_nxt       = '0;
      end
    endcase

    // Power-on request overrides everything and restarts from slot 0.
    if (por_req) begin
      seq_state_nxt = ST_PWR_CKEN;
      cnt_nxt       = '0;
      idx_nxt       = '0;
      cken_nxt      = '0;
      grst_nxt      = 1'b0;
      gdbg_nxt      = 1'b0;
      done_nxt      = 1'b0;
      pend_wrm_nxt  = 1'b0;
      pend_dbg_nxt  = 1'b0;
    end
  end

  // Drive the outputs. busy is decoded from the state, so it reads 1 during arst.
  assign cluster_cken = cken_q;
  assign grst_l       = grst_q;
  assign gdbginit_l   = gdbg_q;
  assign seq_done     = done_q;
  assign seq_busy     = (seq_state != ST_RUN);

endmodule

// File: tb/tb_ctu_cluster_rst_seq.sv
// tb_ctu_cluster_rst_seq
// Directed scenarios followed by a random request phase. Each output is
// compared on every falling edge against a phase/timestamp reference model.
module tb_ctu_cluster_rst_seq;

  localparam int N    = 4;
  localparam int STG  = 4;
  localparam int SYNC = 8;
  localparam int DBG  = 16;
  localparam int CW   = 8;

  // ---------------- clock / reset block ----------------
  logic         gclk = 1'b0;
  logic         arst = 1'b1;
  logic [N-1:0] cken_mask = 4'b1011;
  logic         por_req = 1'b0;
  logic         wrm_req = 1'b0;
  logic         dbg_req = 1'b0;
  logic [N-1:0] cluster_cken;
  logic         grst_l, gdbginit_l, seq_busy, seq_done;

  always #5 gclk = ~gclk;

  ctu_cluster_rst_seq #(
    .NUM_CLUSTERS(N), .STAGGER_CYC(STG), .SYNC_CYC(SYNC), .DBG_CYC(DBG), .CNTW(CW)
  ) dut (
    .gclk(gclk), .arst(arst), .cken_mask(cken_mask), .por_req(por_req),
    .wrm_req(wrm_req), .dbg_req(dbg_req), .cluster_cken(cluster_cken),
    .grst_l(grst_l), .gdbginit_l(gdbginit_l), .seq_busy(seq_busy), .seq_done(seq_done)
  );

  // ---------------- reference model ----------------
  // The model tracks the kind of sequence that is running and the edge it
  // started on. The output levels follow from the elapsed edges.
  typedef enum {K_POR, K_WRM, K_DBG, K_RUN} kind_e;
  kind_e        m_kind;
  int           m_start;
  int           n;
  bit           m_pw, m_pd;
  logic [N-1:0] m_cken;
  logic         m_done;
  int           tests = 0;
  int           fails = 0;

  function automatic int phase_end(kind_e k, int s);
    case (k)
      K_POR:   return s + N * STG + 2 * SYNC;
      K_WRM:   return s + 2 * SYNC;
      K_DBG:   return s + DBG;
      default: return -1;
    endcase
  endfunction

  function automatic logic exp_grst();
    case (m_kind)
      K_POR:   return (n - m_start) >= N * STG + SYNC;
      K_WRM:   return (n - m_start) >= SYNC;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_kind  = K_POR;
    m_start = n;
    m_pw    = 0;
    m_pd    = 0;
    m_cken  = '0;
    m_done  = 0;
  endtask

  // Advance the model by one rising edge, using the inputs sampled at that edge.
  task automatic model_step();
    if (arst || por_req) begin
      model_reset();
    end else if (m_kind == K_RUN) begin
      m_done = 0;
      if (wrm_req || m_pw) begin
        m_kind = K_WRM; m_start = n; m_pw = 0; m_pd = 0;
      end else if (dbg_req || m_pd) begin
        m_kind = K_DBG; m_start = n; m_pd = 0;
      end else begin
        m_cken = cken_mask;
      end
    end else begin
      m_done = 0;
      m_pw = m_pw | wrm_req;
      m_pd = m_pd | dbg_req;
      if (m_kind == K_POR)
        for (int i = 0; i < N; i++)
          if (n - m_start == (i + 1) * STG) m_cken[i] = cken_mask[i];
      if (n == phase_end(m_kind, m_start)) begin
        m_kind = K_RUN;
        m_done = 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs();
    logic gd_exp;
    gd_exp = (m_kind == K_RUN);
    tests++;
    assert (cluster_cken === m_cken) else begin
      fails++;
      $error("FAIL cken edge %0d: got %b exp %b", n, cluster_cken, m_cken);
    end
    tests++;
    assert (grst_l === exp_grst()) else begin
      fails++;
      $error("FAIL grst_l edge %0d: got %b exp %b", n, grst_l, exp_grst());
    end
    tests++;
    assert (gdbginit_l === gd_exp) else begin
      fails++;
      $error("FAIL gdbginit_l edge %0d: got %b exp %b", n, gdbginit_l, gd_exp);
    end
    tests++;
    assert (seq_done === m_done) else begin
      fails++;
      $error("FAIL seq_done edge %0d: got %b exp %b", n, seq_done, m_done);
    end
    tests++;
    assert (seq_busy === (m_kind != K_RUN)) else begin
      fails++;
      $error("FAIL seq_busy edge %0d: got %b exp %b", n, seq_busy, m_kind != K_RUN);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge gclk);
    n++;
    model_step();
    @(negedge gclk);
    check_outputs();
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic pulse_req(input bit w, input bit d, input bit p);
    wrm_req = w; dbg_req = d; por_req = p;
    tick();
    wrm_req = 0; dbg_req = 0; por_req = 0;
  endtask

  task automatic assert_arst();
    arst = 1'b1;
    #1;
    model_reset();
    check_outputs();
  endtask

  // Count the seq_done pulses over a window and compare with the expected number.
  task automatic count_done(input int k, input int want, input string tag);
    int dn;
    dn = 0;
    for (int i = 0; i < k; i++) begin
      tick();
      if (seq_done === 1'b1) dn++;
    end
    tests++;
    assert (dn === want) else begin
      fails++;
      $error("FAIL %s: got %0d done pulses exp %0d", tag, dn, want);
    end
  endtask

  // Stop with a FAIL line if the run does not end well within its time budget.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the summary line");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    n = 0;
    #1;
    model_reset();
    check_outputs();
    ticks(2);
    @(negedge gclk);
    arst = 1'b0;

    // 1: power-on sequence with mask 1011.
    count_done(40, 1, "por_done");

    // 2: standalone debug init.
    pulse_req(0, 1, 0);
    count_done(20, 1, "dbg_done");

    // 3: warm reset.
    pulse_req(1, 0, 0);
    count_done(20, 1, "wrm_done");

    // 4: warm and debug requested together, only the warm sequence runs.
    wrm_req = 1; dbg_req = 1;
    tick();
    wrm_req = 0; dbg_req = 0;
    count_done(40, 1, "wrm_dbg_done");

    // 5: debug request parked during the power-on RST_HOLD phase.
    pulse_req(0, 0, 1);
    ticks(18);
    pulse_req(0, 1, 0);
    count_done(50, 2, "pend_dbg_done");

    // 6: por in the middle of DBG_PULSE, then arst in the middle of PWR_CKEN.
    pulse_req(0, 1, 0);
    ticks(5);
    pulse_req(0, 0, 1);
    ticks(6);
    assert_arst();
    ticks(3);
    arst = 1'b0;
    count_done(40, 1, "arst_restart_done");

    // Random phase: sparse requests and mask changes.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 49) == 0) cken_mask = N'($urandom_range(0, (1 << N) - 1));
      wrm_req = ($urandom_range(0, 39) == 0);
      dbg_req = ($urandom_range(0, 29) == 0);
      por_req = ($urandom_range(0, 299) == 0);
      tick();
      if (c == 1200) begin
        wrm_req = 0; dbg_req = 0; por_req = 0;
        assert_arst();
        tick();
        arst = 1'b0;
      end
    end
    wrm_req = 0; dbg_req = 0; por_req = 0;
    ticks(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
